rr_burst_arbiter: RTL

Parameterized round-robin arbiter that shares one bus among `N` requesters with burst ownership. A granted requester keeps the bus until it releases it, drops its request, or uses up a fixed quantum of cycles. The block inserts a one-cycle turnaround between owners so drivers never overlap. It sits in front of the shared datapath and replaces the fixed three-way grant sequencer with a scalable, starvation-free scheduler.

---
 rtl/rr_burst_arbiter_pkg.sv | 16 +
 rtl/rr_burst_arbiter_if.sv | 23 ++
 rtl/rr_burst_arbiter_pick.sv | 27 ++
 rtl/rr_burst_arbiter.sv | 117 +++++++++++
 4 files changed

// File: rtl/rr_burst_arbiter_pkg.sv
// Shared definitions for the burst arbiter family: FSM encoding and width helpers.
package arb_pkg;

    // Encoding 2'b11 is unused and steers back to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        TURN  = 2'b10
    } arb_state_e;

    // Counter width for a value range, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/rr_burst_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
// 'release' is a language keyword, so the release vector is carried as 'rel'.
interface rr_burst_arbiter_if #(
    parameter int N   = 3,
    parameter int IDW = $clog2(N)
);
    logic [N-1:0]   req;
    logic [N-1:0]   rel;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic           expired;

    modport master (
        output req, rel,
        input  gnt, gnt_valid, gnt_id, expired
    );

    modport slave (
        input  req, rel,
        output gnt, gnt_valid, gnt_id, expired
    );
endinterface

// File: rtl/rr_burst_arbiter_pick.sv
// Rotating-priority find-first: first set request at or above ptr_i, wrapping modulo N.
module rr_pick #(
    parameter int N   = 3,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic           found_o,
    output logic [IDW-1:0] idx_o
);

    // Walk the N candidate positions starting at the pointer; keep the first hit.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = 0; i < N; i++) begin
            logic [IDW-1:0] cand;
            cand = IDW'((int'(ptr_i) + i) % N);
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin bus arbiter with burst ownership, quantum limit and a one-cycle turnaround.
module rr_burst_arbiter
    import arb_pkg::*;
#(
    parameter int N       = 3,
    parameter int QUANTUM = 4
) (
    input logic              clk,
    input logic              reset,
    rr_burst_arbiter_if.slave bus
);

    localparam int IDW = $clog2(N);
    localparam int HCW = clog2_min1(QUANTUM);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [HCW-1:0] hcnt_q, hcnt_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic           gnt_valid_q;
    logic           expired_q, expired_d;

    logic           pick_found;
    logic [IDW-1:0] pick_idx;

    logic           end_rel;
    logic           end_drop;
    logic           end_quantum;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Burst end causes for the current owner; only the owner's release bit matters.
    always_comb begin
        end_rel     = bus.rel[gnt_id_q];
        end_drop    = !bus.req[gnt_id_q];
        end_quantum = (hcnt_q == HCW'(QUANTUM - 1));
    end

    // Next-state and next-output logic for the IDLE/GRANT/TURN controller.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hcnt_d    = hcnt_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        expired_d = 1'b0;

        unique case (state_q)
            IDLE, TURN: begin
                if (pick_found) begin
                    state_d         = GRANT;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    gnt_id_d        = pick_idx;
                    ptr_d           = (pick_idx == IDW'(N - 1)) ? '0 : pick_idx + 1'b1;
                    hcnt_d          = '0;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            GRANT: begin
                if (end_rel || end_drop || end_quantum) begin
                    state_d   = TURN;
                    gnt_d     = '0;
                    hcnt_d    = '0;
                    // Flag the quantum only when it alone forced the handover.
                    expired_d = end_quantum && !end_rel && !end_drop;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                hcnt_d  = '0;
            end
        endcase
    end

    // State and output registers; synchronous active-low reset wins over everything.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so all of them see pre-edge values.
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hcnt_q      <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hcnt_q      <= hcnt_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= |gnt_d;
            expired_q   <= expired_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.expired   = expired_q;

endmodule
